// File: rtl/rr_buf_arb_pkg.sv
// Shared definitions for the round-robin buffered arbiter.
// Holds the buffer state encoding and the source-tag width helper.
package rr_buf_arb_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Source tag width: at least one bit even for tiny requester counts
    function automatic int src_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: scans from last_grant+1 upward, wrapping.
// Purely combinational; reports any_valid, winner index and one-hot.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] last_grant,
    output logic             any_valid,
    output logic [SRC_W-1:0] winner,
    output logic [N_REQ-1:0] onehot
);

    // Upper half (above last_grant) first, then wrap to the lower half
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        onehot    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_valid && req[i] && (i > int'(last_grant))) begin
                any_valid = 1'b1;
                winner    = SRC_W'(i);
                onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_valid && req[i] && (i <= int'(last_grant))) begin
                any_valid = 1'b1;
                winner    = SRC_W'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_buf_arbiter.sv
// Round-robin arbiter feeding one single-entry output buffer.
// Each forwarded word carries the index of the requester it came from.
module rr_buf_arbiter
    import rr_buf_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int SRC_W  = src_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic                    busy
);

    logic              state_q;
    logic              state_d;
    logic [SRC_W-1:0]  last_grant;
    logic              any_valid;
    logic [SRC_W-1:0]  winner;
    logic [N_REQ-1:0]  onehot;
    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any_valid  (any_valid),
        .winner     (winner),
        .onehot     (onehot)
    );

    // Loading is allowed into an empty buffer or one draining this cycle
    assign can_load  = (state_q == ST_EMPTY) || out_ready;
    assign load      = any_valid && can_load && !rst;
    assign req_ready = (rst || !can_load) ? '0 : onehot;
    assign out_valid = (state_q == ST_FULL);
    assign busy      = out_valid || (|req_valid);

    // One-hot mux of the winning requester's word
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (onehot[i]) begin
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Buffer fill/drain sequencing; a load wins over a plain drain
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Buffer contents and priority pointer move only on an accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SRC_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (load) begin
                out_data   <= sel_data;
                out_src    <= winner;
                last_grant <= winner;
            end
        end
    end

endmodule

// File: doc/rr_buf_arbiter.md
Name: rr_buf_arbiter

Overview:
- Shares one single-entry output buffer stage among N_REQ requesters using round-robin arbitration and valid/ready handshakes on both sides.
- Sits between several producer lanes and one downstream consumer.
- Tags each forwarded word with its source index.
- Sequences the buffer's fill/drain so that each accepted word is passed through exactly once and unmodified.

Parameters:
- N_REQ, 4: number of requesters. Legal range 2..16.
- DATA_W, 8: data width per requester and on the output.
- SRC_W, derived as max(1, clog2(N_REQ)): width of the source tag. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i offers a word.
- req_data  input  N_REQ*DATA_W  requester i's word is in bits [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot or zero; bit i: word i is accepted this cycle.
- out_valid  output  1  the buffer holds a word.
- out_data  output  DATA_W  the buffered word.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  out_valid OR any req_valid.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - Internal last_grant=N_REQ-1, so requester 0 has the highest priority after reset.
  - req_ready=0 while rst is high.
  - busy follows its combinational definition.
- Buffer states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = EMPTY OR (FULL AND out_ready). This is a combinational path from out_ready to req_ready; the path is intentional.
- Arbitration (combinational):
  - Scan requesters starting at (last_grant+1) mod N_REQ, wrapping around.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner]=can_load. All other req_ready bits are 0.
  - No valid requester means req_ready is all zero.
- Transfer in (req_valid[i] AND req_ready[i]):
  - Next cycle: out_data=req_data[i], out_src=i, out_valid=1, last_grant=i.
  - Latency is 1 cycle from acceptance to out_valid.
- Drain without refill (FULL AND out_ready AND no transfer in): next cycle out_valid=0. out_data and out_src keep their last values.
- Simultaneous drain and load: the buffer stays FULL with the new word. This gives full throughput of one word per cycle.
- Stall (FULL AND NOT out_ready): out_valid, out_data and out_src are held stable. req_ready is all zero. last_grant is unchanged.
- last_grant updates only on an accepted transfer. Offered but unaccepted requests do not rotate priority.
- Fairness: a requester that holds req_valid high is accepted within N_REQ consecutive accepted transfers.
- Protocol obligation on requesters: once req_valid[i] rises, req_valid[i] and its data stay stable until accepted. The block does not check this. A requester may drop valid before acceptance; it then simply loses arbitration.
- Reset asserted mid-operation: a buffered word is discarded (out_valid=0 the cycle after rst is sampled). Priority returns to requester 0.
- Data is never altered, duplicated or dropped. Every accepted word appears exactly once at the output.

Decomposition:
- Package rr_buf_arb_pkg:
  - function src_width(n), returning max(1, clog2(n)).
  - localparams for the buffer state encoding: ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module rr_pick:
  - Purely combinational rotate-priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: any_valid, winner index, one-hot winner.
  - Parameterised by N_REQ.
- Top level keeps the buffer register, last_grant register and handshake logic.

Test Plan:
1. Reset, then req_valid=4'b0001 with data 0x11, out_ready=1 -> req_ready=0001 in the same cycle. Next cycle out_valid=1, out_data=0x11, out_src=0. The cycle after, out_valid=0.
2. All four requesters valid continuously (data 0xA0..0xA3), out_ready=1 -> output sequence src 0,1,2,3,0,1... with one word every cycle and no bubbles.
3. Buffer FULL with 0x22 from src 2, out_ready=0 for 5 cycles, req_valid=1011 -> out_data stays 0x22 and req_ready=0000 throughout. When out_ready rises, src 3 is accepted in that same cycle (last_grant=2).
4. req_valid=0100 only, then 0101 after src 2 is accepted, out_ready=1 -> next grant is src 0 (wrap-around past index 3), then src 2.
5. rst asserted while FULL with out_valid=1, out_data=0x5A -> next cycle out_valid=0, out_data=0, out_src=0. First post-reset grant with all valid goes to src 0.
6. N_REQ=2, DATA_W=16, random valid/ready with a scoreboard -> no loss, duplication or reordering per source. Maximum wait per requester is at most 2 accepted transfers.
